// File: rtl/fetch_sequencer.sv
// Program-fetch controller: owns the PC into the instruction ROM, runs the start/done
// handshake, resolves taken branches through an 8-entry target table and stops on halt.
module fetch_sequencer #(
  parameter int unsigned A = 10,
  parameter int unsigned W = 9
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] StartAddr,
  input  logic         Stall,
  input  logic         BranchTaken,
  input  logic [2:0]   BranchSel,
  input  logic         LutWe,
  input  logic [2:0]   LutIdx,
  input  logic [A-1:0] LutData,
  input  logic [W-1:0] InstIn,
  output logic [A-1:0] InstAddress,
  output logic         InstValid,
  output logic         Busy,
  output logic         Done,
  output logic [15:0]  InstCount
);

  localparam int unsigned CW = 16;
  localparam int unsigned NT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [A-1:0]    pc;
  logic [A-1:0]    pc_next;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [A-1:0]    lut [NT];
  logic            busy_q;
  logic            done_q;

  logic            exec;
  logic            halt;
  logic            launch;
  logic            lut_wr;

  // State register; Busy/Done are registered copies of the upcoming state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next == RUN);
      done_q <= (state_next == DONE);
    end
  end

  // Next-state logic: halt is the only way out of RUN short of reset.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (halt)  state_next = DONE;
      DONE:    if (Start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; a stalled cycle suppresses execution, which also masks halt and branch.
  always_comb begin
    exec   = 1'b0;
    halt   = 1'b0;
    launch = 1'b0;
    lut_wr = 1'b0;
    if (state == RUN) begin
      exec = !Stall;
      halt = !Stall && (InstIn == {W{1'b1}});
    end else begin
      launch = Start;
      lut_wr = LutWe;
    end
  end

  // PC and retire-count next values; halt keeps the PC parked on the halt word.
  always_comb begin
    pc_next    = pc;
    count_next = count;
    if (launch) begin
      pc_next    = StartAddr;
      count_next = '0;
    end else if (exec) begin
      if (!halt) begin
        pc_next = BranchTaken ? lut[BranchSel] : pc + A'(1);
      end
      if (count != {CW{1'b1}}) begin
        count_next = count + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc    <= '0;
      count <= '0;
    end else begin
      pc    <= pc_next;
      count <= count_next;
    end
  end

  // Branch-target table, writable only while not running.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(NT); i++) begin
        lut[i] <= '0;
      end
    end else if (lut_wr) begin
      lut[LutIdx] <= LutData;
    end
  end

  assign InstAddress = pc;
  assign InstValid   = exec;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign InstCount   = count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a program-level model predicts executed addresses
// and final counts; a negedge monitor compares every executed instruction.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [9:0]  StartAddr = '0;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [2:0]  BranchSel = '0;
  logic        LutWe = 1'b0;
  logic [2:0]  LutIdx = '0;
  logic [9:0]  LutData = '0;
  logic [8:0]  InstIn;
  logic [9:0]  InstAddress;
  logic        InstValid;
  logic        Busy;
  logic        Done;
  logic [15:0] InstCount;

  logic [8:0]  rom [1024];
  assign InstIn = rom[InstAddress];

  fetch_sequencer #(.A(10), .W(9)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchSel(BranchSel), .LutWe(LutWe), .LutIdx(LutIdx),
    .LutData(LutData), .InstIn(InstIn), .InstAddress(InstAddress), .InstValid(InstValid),
    .Busy(Busy), .Done(Done), .InstCount(InstCount)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       stall;
    logic       br;
    logic [2:0] sel;
    logic       lut;
    logic [2:0] lidx;
    logic [9:0] ldata;
    logic       start;
    logic [9:0] saddr;
  } stim_t;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [9:0]  exp_q [$];
  stim_t       plan [$];
  logic [9:0]  tbl [8];
  logic [9:0]  m_pc = '0;
  logic [15:0] m_cnt = '0;
  bit          m_run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every executed instruction must match the next predicted address.
  always @(negedge Clk) begin
    logic [9:0] e;
    check("busy", 32'(Busy), 32'(m_run));
    if (m_run && !Stall) begin
      check("inst_valid", 32'(InstValid), 32'd1);
      if (exp_q.size() == 0) begin
        check("exp_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("inst_addr", 32'(InstAddress), 32'(e));
      end
    end else begin
      check("inst_valid_idle", 32'(InstValid), 32'd0);
    end
  end

  function automatic stim_t mk(input bit s, input bit b, input int sel);
    stim_t t;
    t = '0;
    t.stall = s;
    t.br = b;
    t.sel = 3'(sel);
    return t;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t t;
    t.stall = ($urandom_range(0, 3) == 0);
    t.br    = ($urandom_range(0, 4) == 0);
    t.sel   = 3'($urandom_range(0, 7));
    t.lut   = ($urandom_range(0, 7) == 0);
    t.lidx  = 3'($urandom_range(0, 7));
    t.ldata = 10'($urandom_range(0, 1023));
    t.start = ($urandom_range(0, 7) == 0);
    t.saddr = 10'($urandom_range(0, 1023));
    return t;
  endfunction

  task automatic rom_clear();
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
  endtask

  task automatic do_reset(input bit chk);
    Reset = 1'b0;
    Start = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; LutWe = 1'b0;
    m_run = 1'b0;
    m_pc = '0;
    m_cnt = '0;
    for (int i = 0; i < 8; i++) tbl[i] = '0;
    #1;
    if (chk) begin
      check("rst_addr", 32'(InstAddress), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_valid", 32'(InstValid), 32'd0);
      check("rst_count", 32'(InstCount), 32'd0);
    end
    exp_q.delete();
    @(posedge Clk); #1;
    Reset = 1'b1;
  endtask

  task automatic lut_write(input int idx, input logic [9:0] data);
    LutWe = 1'b1; LutIdx = 3'(idx); LutData = data;
    @(posedge Clk); #1;
    LutWe = 1'b0;
    tbl[idx] = data;
  endtask

  task automatic start_prog(input logic [9:0] sa, input bit with_lut);
    int idx;
    logic [9:0] data;
    idx = $urandom_range(0, 7);
    data = 10'($urandom_range(0, 1023));
    Start = 1'b1; StartAddr = sa;
    if (with_lut) begin
      LutWe = 1'b1; LutIdx = 3'(idx); LutData = data;
    end
    @(posedge Clk); #1;
    Start = 1'b0; LutWe = 1'b0;
    if (with_lut) tbl[idx] = data;
    m_pc = sa;
    m_cnt = '0;
    m_run = 1'b1;
  endtask

  // Drives one program to its halt; reset_at >= 0 asserts reset when that address is reached.
  task automatic run_prog(input bit rnd, input int reset_at);
    stim_t st;
    bit halted = 1'b0;
    int cyc = 0;
    logic [15:0] cnt_hold;
    while (!halted && cyc < 600) begin
      if (plan.size() > 0) st = plan.pop_front();
      else if (rnd) st = rnd_stim();
      else st = '0;
      if (reset_at >= 0 && int'(m_pc) == reset_at) begin
        do_reset(1'b1);
        return;
      end
      Stall = st.stall; BranchTaken = st.br; BranchSel = st.sel;
      LutWe = st.lut; LutIdx = st.lidx; LutData = st.ldata;
      Start = st.start; StartAddr = st.saddr;
      if (!st.stall) begin
        exp_q.push_back(m_pc);
        if (rom[m_pc] == 9'h1FF) halted = 1'b1;
        else if (st.br) m_pc = tbl[st.sel];
        else m_pc = m_pc + 10'd1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      @(posedge Clk); #1;
      Stall = 1'b0; BranchTaken = 1'b0; LutWe = 1'b0; Start = 1'b0;
      cyc++;
    end
    if (!halted) begin
      check("halt_timeout", 32'(halted), 32'd1);
      do_reset(1'b0);
      return;
    end
    m_run = 1'b0;
    check("done", 32'(Done), 32'd1);
    check("count", 32'(InstCount), 32'(m_cnt));
    check("halt_addr", 32'(InstAddress), 32'(m_pc));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    cnt_hold = m_cnt;
    repeat (2) @(posedge Clk);
    #1;
    check("done_hold", 32'(Done), 32'd1);
    check("addr_hold", 32'(InstAddress), 32'(m_pc));
    check("count_hold", 32'(InstCount), 32'(cnt_hold));
  endtask

  initial begin
    stim_t s;
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 8; i++) tbl[i] = '0;
    rom_clear();
    repeat (2) @(posedge Clk);
    #1;
    do_reset(1'b1);

    // Straight-line program halting at 4.
    rom[4] = 9'h1FF;
    start_prog(10'd0, 1'b0);
    run_prog(1'b0, -1);

    // Taken branch through table[3] = 20.
    lut_write(3, 10'd20);
    rom_clear(); rom[21] = 9'h1FF;
    plan.push_back(mk(0, 0, 0));
    plan.push_back(mk(0, 0, 0));
    plan.push_back(mk(0, 1, 3));
    start_prog(10'd0, 1'b0);
    run_prog(1'b0, -1);

    // Stall held 3 cycles at address 1 with a pending branch.
    rom_clear(); rom[4] = 9'h1FF;
    plan.push_back(mk(0, 0, 0));
    repeat (3) plan.push_back(mk(1, 1, 3));
    start_prog(10'd0, 1'b0);
    run_prog(1'b0, -1);

    // PC wrap from 3FF to 0.
    rom_clear(); rom[1] = 9'h1FF;
    start_prog(10'h3FF, 1'b0);
    run_prog(1'b0, -1);

    // Table write during RUN is dropped; branch via index 0 lands on 0.
    s = mk(0, 0, 0); s.lut = 1'b1; s.lidx = 3'd0; s.ldata = 10'd50;
    plan.push_back(s);
    plan.push_back(mk(0, 1, 0));
    start_prog(10'd5, 1'b0);
    run_prog(1'b0, -1);

    // Start in RUN is ignored, then reset mid-RUN at address 7 and restart.
    rom_clear();
    s = mk(0, 0, 0); s.start = 1'b1; s.saddr = 10'd100;
    plan.push_back(s);
    start_prog(10'd5, 1'b0);
    run_prog(1'b0, 7);
    plan.delete();
    rom[3] = 9'h1FF;
    start_prog(10'd0, 1'b1);
    run_prog(1'b0, -1);

    // Randomized programs, tables and per-cycle stimulus.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 1024; i++) begin
        rom[i] = ($urandom_range(0, 11) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
      end
      repeat ($urandom_range(0, 3)) lut_write($urandom_range(0, 7), 10'($urandom_range(0, 1023)));
      start_prog(10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
      run_prog(1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
